// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock timebase controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between the CSR side (master) and the timebase controller (slave).
interface clk_div_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick_rise;
  logic             tick_fall;
  logic             running;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, clk_out, tick_rise, tick_fall, running
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, clk_out, tick_rise, tick_fall, running
  );
endinterface

// File: rtl/div_half_cnt.sv
// Half-period counter: counts while enabled and wraps to 0 at terminal count H-1.
module div_half_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-2:0] i_h,
  output logic             o_tc
);
  logic [WIDTH-1:0] r_cnt;

  // H is at least 1, so H-1 never wraps below zero.
  assign o_tc = (r_cnt == ({1'b0, i_h} - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc ? '0 : r_cnt + WIDTH'(1);
    end
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: glitch-free gating, boundary-aligned divisor updates,
// and registered rise/fall strobes for clock-enable style consumers.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = 500
) (
  input  logic         clk,
  input  logic         rst_n,
  clk_div_ctrl_if.slave io_bus
);
  localparam logic [WIDTH-2:0] DEF_H = (WIDTH-1)'(DEF_DIV / 2);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_clk_out;
  logic             r_tick_rise;
  logic             r_tick_fall;
  logic             r_cfg_err;
  logic [WIDTH-2:0] r_h;
  logic [WIDTH-2:0] r_pend_h;
  logic             r_pend_valid;
  logic             r_pend_idle;

  logic w_tc;
  logic w_active;
  logic w_toggle;
  logic w_fall;
  logic w_xfer;
  logic w_div_ok;
  logic w_apply;
  logic w_clr;
  logic w_clk_out_next;
  logic w_rise_next;

  assign w_active = (r_state != IDLE);
  assign w_toggle = w_active && w_tc;
  assign w_fall   = w_toggle && r_clk_out;
  assign w_xfer   = io_bus.cfg_valid && !r_pend_valid;
  assign w_div_ok = (io_bus.cfg_div >= WIDTH'(MIN_DIV));
  // A divisor accepted while idle was already loaded into r_h; r_pend_idle only
  // retires it one edge later so cfg_ready behaves the same in every state.
  assign w_apply  = r_pend_valid && ((r_state == IDLE) || r_pend_idle || w_fall);

  div_half_cnt #(.WIDTH(WIDTH)) u_half_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_active),
    .i_h   (r_h),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_clk_out    <= 1'b0;
      r_tick_rise  <= 1'b0;
      r_tick_fall  <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_h          <= DEF_H;
      r_pend_h     <= '0;
      r_pend_valid <= 1'b0;
      r_pend_idle  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clk_out   <= w_clk_out_next;
      r_tick_rise <= w_rise_next;
      r_tick_fall <= w_fall;
      r_cfg_err   <= w_xfer && !w_div_ok;
      if (w_xfer && w_div_ok) begin
        r_pend_valid <= 1'b1;
        r_pend_h     <= io_bus.cfg_div[WIDTH-1:1];
        r_pend_idle  <= (r_state == IDLE);
        if (r_state == IDLE) begin
          r_h <= io_bus.cfg_div[WIDTH-1:1];
        end
      end else if (w_apply) begin
        r_pend_valid <= 1'b0;
        r_pend_idle  <= 1'b0;
        r_h          <= r_pend_h;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (io_bus.en) w_state_next = RUN;
      end
      RUN: begin
        // A low phase may be cut short; a high phase must finish first.
        if (!io_bus.en) begin
          if (!r_clk_out || w_fall) w_state_next = IDLE;
          else                      w_state_next = STOP_PEND;
        end
      end
      STOP_PEND: begin
        if (io_bus.en)   w_state_next = RUN;
        else if (w_fall) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_clr          = (w_state_next == IDLE);
    w_clk_out_next = r_clk_out;
    w_rise_next    = 1'b0;
    if (w_state_next == IDLE) begin
      w_clk_out_next = 1'b0;
    end else if (w_toggle) begin
      w_clk_out_next = !r_clk_out;
      w_rise_next    = !r_clk_out;
    end
  end

  assign io_bus.cfg_ready = !r_pend_valid;
  assign io_bus.cfg_err   = r_cfg_err;
  assign io_bus.clk_out   = r_clk_out;
  assign io_bus.tick_rise = r_tick_rise;
  assign io_bus.tick_fall = r_tick_fall;
  assign io_bus.running   = w_active;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed vector table, random run against a phase-countdown
// reference model, and hand-written reset/DEF_DIV timing sequences.
module tb_clk_div_ctrl;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   cyc;

  clk_div_ctrl_if #(.WIDTH(W)) bus ();

  clk_div_ctrl #(.WIDTH(W), .DEF_DIV(500)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle / 1 run / 2 stopping, m_left = cycles left in the phase.
  int m_mode;
  bit m_lvl;
  int m_left;
  int m_h;
  bit m_pend;
  int m_pend_h;
  int m_rel;
  bit e_rise, e_fall, e_err;

  task automatic model_reset();
    m_mode = 0; m_lvl = 1'b0; m_left = 0; m_h = 250;
    m_pend = 1'b0; m_pend_h = 0; m_rel = -1;
    e_rise = 1'b0; e_fall = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit v, input int div);
    bit xfer;
    bit ok;
    int old_mode;
    xfer = v && !m_pend;
    ok = (div >= 2);
    old_mode = m_mode;
    e_rise = 1'b0; e_fall = 1'b0; e_err = xfer && !ok;
    if (m_pend && (m_mode == 0 || m_rel == cyc)) begin
      m_h = m_pend_h; m_pend = 1'b0;
    end
    if (xfer && ok && m_mode == 0) m_h = div / 2;
    if (m_mode == 0) begin
      if (en) begin m_mode = 1; m_left = m_h; end
    end else if (m_mode == 1 && !en && !m_lvl) begin
      m_mode = 0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_lvl = !m_lvl;
        if (m_lvl) e_rise = 1'b1;
        else begin
          e_fall = 1'b1;
          if (m_pend) begin m_h = m_pend_h; m_pend = 1'b0; end
        end
        m_left = m_h;
      end
      if (en)          m_mode = 1;
      else if (!m_lvl) m_mode = 0;
      else             m_mode = 2;
    end
    if (xfer && ok) begin
      m_pend = 1'b1; m_pend_h = div / 2;
      m_rel = (old_mode == 0) ? cyc + 1 : -1;
    end
  endtask

  task automatic cycle(input bit en, input bit v, input int div);
    @(negedge clk);
    bus.en = en; bus.cfg_valid = v; bus.cfg_div = W'(div);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(en, v, div);
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // exp bits: {clk_out, tick_rise, tick_fall, cfg_err, running, cfg_ready}
  task automatic chk_out(input string tag, input bit [5:0] exp);
    chk({tag, ".clk_out"},   32'(bus.clk_out),   32'(exp[5]));
    chk({tag, ".tick_rise"}, 32'(bus.tick_rise), 32'(exp[4]));
    chk({tag, ".tick_fall"}, 32'(bus.tick_fall), 32'(exp[3]));
    chk({tag, ".cfg_err"},   32'(bus.cfg_err),   32'(exp[2]));
    chk({tag, ".running"},   32'(bus.running),   32'(exp[1]));
    chk({tag, ".cfg_ready"}, 32'(bus.cfg_ready), 32'(exp[0]));
  endtask

  typedef struct {
    bit      en;
    bit      v;
    int      div;
    bit [5:0] exp;
  } vec_t;

  vec_t tbl[42];

  function automatic vec_t mk(input bit en, input bit v, input int div, input bit [5:0] exp);
    vec_t r;
    r.en = en; r.v = v; r.div = div; r.exp = exp;
    return r;
  endfunction

  int n, pos_fall, falls, rises;
  bit en_r;

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;
    model_reset();

    // div=4 from idle, div=8 mid-high, stop/restart, bad divisors, odd divisor 7.
    tbl[0]  = mk(0, 1, 4, 6'b000000); tbl[1]  = mk(0, 0, 0, 6'b000001);
    tbl[2]  = mk(1, 0, 0, 6'b000011); tbl[3]  = mk(1, 0, 0, 6'b000011);
    tbl[4]  = mk(1, 0, 0, 6'b110011); tbl[5]  = mk(1, 0, 0, 6'b100011);
    tbl[6]  = mk(1, 0, 0, 6'b001011); tbl[7]  = mk(1, 0, 0, 6'b000011);
    tbl[8]  = mk(1, 0, 0, 6'b110011); tbl[9]  = mk(1, 1, 8, 6'b100010);
    tbl[10] = mk(1, 0, 0, 6'b001011); tbl[11] = mk(1, 0, 0, 6'b000011);
    tbl[12] = mk(1, 0, 0, 6'b000011); tbl[13] = mk(1, 0, 0, 6'b000011);
    tbl[14] = mk(1, 0, 0, 6'b110011); tbl[15] = mk(0, 0, 0, 6'b100011);
    tbl[16] = mk(0, 0, 0, 6'b100011); tbl[17] = mk(0, 0, 0, 6'b100011);
    tbl[18] = mk(0, 0, 0, 6'b001001); tbl[19] = mk(1, 0, 0, 6'b000011);
    tbl[20] = mk(1, 0, 0, 6'b000011); tbl[21] = mk(1, 0, 0, 6'b000011);
    tbl[22] = mk(1, 0, 0, 6'b000011); tbl[23] = mk(1, 0, 0, 6'b110011);
    tbl[24] = mk(0, 0, 0, 6'b100011); tbl[25] = mk(1, 0, 0, 6'b100011);
    tbl[26] = mk(1, 0, 0, 6'b100011); tbl[27] = mk(1, 0, 0, 6'b001011);
    tbl[28] = mk(1, 1, 1, 6'b000111); tbl[29] = mk(1, 1, 0, 6'b000111);
    tbl[30] = mk(1, 0, 0, 6'b000011); tbl[31] = mk(1, 0, 0, 6'b110011);
    tbl[32] = mk(1, 1, 7, 6'b100010); tbl[33] = mk(1, 0, 0, 6'b100010);
    tbl[34] = mk(1, 0, 0, 6'b100010); tbl[35] = mk(1, 0, 0, 6'b001011);
    tbl[36] = mk(1, 0, 0, 6'b000011); tbl[37] = mk(1, 0, 0, 6'b000011);
    tbl[38] = mk(1, 0, 0, 6'b110011); tbl[39] = mk(1, 0, 0, 6'b100011);
    tbl[40] = mk(1, 0, 0, 6'b100011); tbl[41] = mk(1, 0, 0, 6'b001011);

    rst_n = 1'b0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    rst_n = 1'b1;
    chk_out("reset", 6'b000001);

    for (int i = 0; i < 42; i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].div);
      chk_out($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Random traffic against the reference model; small divisors keep phases short.
    en_r = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 11) == 0) en_r = !en_r;
      cycle(en_r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 13)));
      chk_out($sformatf("rnd%0d", i), {m_lvl, e_rise, e_fall, e_err, (m_mode != 0), !m_pend});
    end

    // DEF_DIV timing, then reset mid-high with a divisor pending.
    rst_n = 1'b0;
    cycle(0, 0, 0);
    rst_n = 1'b1;
    cycle(1, 0, 0);
    n = 0;
    do begin cycle(1, 0, 0); n++; end while (!bus.tick_rise && n < 600);
    chk("def_first_rise", 32'(n), 32'd250);
    cycle(1, 1, 10);
    chk("pend_ready_low", 32'(bus.cfg_ready), 32'd0);
    chk("pend_clk_high", 32'(bus.clk_out), 32'd1);
    rst_n = 1'b0;
    cycle(1, 0, 0);
    chk_out("rst_mid", 6'b000001);
    rst_n = 1'b1;
    cycle(1, 0, 0);
    n = 0;
    do begin cycle(1, 0, 0); n++; end while (!bus.tick_rise && n < 600);
    chk("restart_first_rise", 32'(n), 32'd250);
    n = 0; falls = 0; rises = 0; pos_fall = -1;
    do begin
      cycle(1, 0, 0); n++;
      if (bus.tick_fall) begin falls++; pos_fall = n; end
      if (bus.tick_rise) rises++;
    end while (!bus.tick_rise && n < 1200);
    chk("restart_period", 32'(n), 32'd500);
    chk("restart_fall_pos", 32'(pos_fall), 32'd250);
    chk("restart_falls", 32'(falls), 32'd1);
    chk("restart_rises", 32'(rises), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
